// File: rtl/timer_pkg.sv
// Shared mode encodings and helpers for the multi-channel timer block.
package timer_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_FREE    = 2'd0;
    localparam logic [MODE_W-1:0] MODE_RELOAD  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'd2;
    localparam logic [MODE_W-1:0] MODE_CAPTURE = 2'd3;

    // Modes whose overflow lands on the reload value instead of wrapping to zero.
    function automatic logic mode_reloads(input logic [MODE_W-1:0] m);
        return (m == MODE_RELOAD) || (m == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer/counter channel: pin synchronisers, falling-edge detect, counter,
// reload and capture registers, and sticky overflow/capture flags.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tr,
    input  logic              gate,
    input  logic              ct,
    input  logic [MODE_W-1:0] mode,
    input  logic              t_pin,
    input  logic              int_pin,
    input  logic              cap_pin,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              clr_ovf,
    input  logic              clr_cap,
    output logic [CNT_W-1:0]  cnt,
    output logic [CNT_W-1:0]  cap,
    output logic              ovf_flag,
    output logic              cap_flag,
    output logic              t_o
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_t_sync;
    logic [SYNC_STAGES-1:0] r_int_sync;
    logic [SYNC_STAGES-1:0] r_cap_sync;
    logic                   r_t_last;
    logic                   r_cap_last;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] r_cap;
    logic             r_ovf_flag;
    logic             r_cap_flag;
    logic             r_t_o;
    logic             r_done;

    logic             w_t_fall;
    logic             w_cap_fall;
    logic             w_int_s;
    logic             w_en;
    logic             w_tick;
    logic             w_wr_cnt;
    logic             w_wr_rld;
    logic             w_ovf;
    logic             w_capture;
    logic             w_done_nx;
    logic [CNT_W-1:0] w_reload_nx;
    logic [CNT_W-1:0] w_cnt_nx;

    // Synchronisers idle high so that leaving reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t_sync   <= '1;
            r_int_sync <= '1;
            r_cap_sync <= '1;
            r_t_last   <= 1'b1;
            r_cap_last <= 1'b1;
        end else begin
            r_t_sync   <= {r_t_sync[SYNC_STAGES-2:0], t_pin};
            r_int_sync <= {r_int_sync[SYNC_STAGES-2:0], int_pin};
            r_cap_sync <= {r_cap_sync[SYNC_STAGES-2:0], cap_pin};
            r_t_last   <= r_t_sync[SYNC_STAGES-1];
            r_cap_last <= r_cap_sync[SYNC_STAGES-1];
        end
    end

    assign w_t_fall   = r_t_last & ~r_t_sync[SYNC_STAGES-1];
    assign w_cap_fall = r_cap_last & ~r_cap_sync[SYNC_STAGES-1];
    assign w_int_s    = r_int_sync[SYNC_STAGES-1];

    always_comb begin
        w_en        = tr & ~r_done & (~gate | w_int_s);
        w_tick      = w_en & (~ct | w_t_fall);
        w_wr_cnt    = wr_en & ~wr_sel;
        w_wr_rld    = wr_en & wr_sel;
        w_reload_nx = w_wr_rld ? wr_data : r_reload;
        // A counter write in the same cycle suppresses the overflow entirely.
        w_ovf       = w_tick & ~w_wr_cnt & (r_cnt == ALL_ONES);
        w_capture   = (mode == MODE_CAPTURE) & w_cap_fall;

        w_cnt_nx = r_cnt;
        if (w_wr_cnt) begin
            w_cnt_nx = wr_data;
        end else if (w_ovf) begin
            w_cnt_nx = mode_reloads(mode) ? w_reload_nx : '0;
        end else if (w_tick) begin
            w_cnt_nx = r_cnt + ONE;
        end

        w_done_nx = r_done;
        if (!tr) begin
            w_done_nx = 1'b0;
        end else if (w_ovf && (mode == MODE_ONESHOT)) begin
            w_done_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_reload   <= '0;
            r_cap      <= '0;
            r_ovf_flag <= 1'b0;
            r_cap_flag <= 1'b0;
            r_t_o      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nx;
            r_reload   <= w_reload_nx;
            r_t_o      <= w_ovf;
            r_done     <= w_done_nx;
            r_ovf_flag <= w_ovf | (r_ovf_flag & ~clr_ovf);
            r_cap_flag <= w_capture | (r_cap_flag & ~clr_cap);
            if (w_capture) begin
                r_cap <= r_cnt;
            end
        end
    end

    assign cnt      = r_cnt;
    assign cap      = r_cap;
    assign ovf_flag = r_ovf_flag;
    assign cap_flag = r_cap_flag;
    assign t_o      = r_t_o;

endmodule

// File: rtl/timer_array.sv
// Array of independent timer/counter channels; channel i owns slice i of every
// per-channel bus.
module timer_array
    import timer_pkg::*;
#(
    parameter int CH          = 2,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        tr,
    input  logic [CH-1:0]        gate,
    input  logic [CH-1:0]        ct,
    input  logic [MODE_W*CH-1:0] mode,
    input  logic [CH-1:0]        t_pin,
    input  logic [CH-1:0]        int_pin,
    input  logic [CH-1:0]        cap_pin,
    input  logic [CH-1:0]        wr_en,
    input  logic                 wr_sel,
    input  logic [CNT_W-1:0]     wr_data,
    input  logic [CH-1:0]        clr_ovf,
    input  logic [CH-1:0]        clr_cap,
    output logic [CH*CNT_W-1:0]  cnt,
    output logic [CH*CNT_W-1:0]  cap,
    output logic [CH-1:0]        ovf_flag,
    output logic [CH-1:0]        cap_flag,
    output logic [CH-1:0]        t_o
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        timer_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tr       (tr[g]),
            .gate     (gate[g]),
            .ct       (ct[g]),
            .mode     (mode[g*MODE_W +: MODE_W]),
            .t_pin    (t_pin[g]),
            .int_pin  (int_pin[g]),
            .cap_pin  (cap_pin[g]),
            .wr_en    (wr_en[g]),
            .wr_sel   (wr_sel),
            .wr_data  (wr_data),
            .clr_ovf  (clr_ovf[g]),
            .clr_cap  (clr_cap[g]),
            .cnt      (cnt[g*CNT_W +: CNT_W]),
            .cap      (cap[g*CNT_W +: CNT_W]),
            .ovf_flag (ovf_flag[g]),
            .cap_flag (cap_flag[g]),
            .t_o      (t_o[g])
        );
    end

endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array: table-driven vectors, hand-written corner sequences and
// randomized traffic checked against a behavioural model.
module tb_timer_array;

    localparam int CH    = 2;
    localparam int CNT_W = 16;
    localparam int S     = 2;
    localparam int unsigned MAXV = (32'd1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       tr, gate, ct, t_pin, int_pin, cap_pin, wr_en, clr_ovf, clr_cap;
    logic [2*CH-1:0]     mode;
    logic                wr_sel;
    logic [CNT_W-1:0]    wr_data;
    logic [CH*CNT_W-1:0] cnt, cap;
    logic [CH-1:0]       ovf_flag, cap_flag, t_o;

    int checks   = 0;
    int failures = 0;

    timer_array #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .tr(tr), .gate(gate), .ct(ct), .mode(mode),
        .t_pin(t_pin), .int_pin(int_pin), .cap_pin(cap_pin),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .clr_cap(clr_cap),
        .cnt(cnt), .cap(cap), .ovf_flag(ovf_flag), .cap_flag(cap_flag), .t_o(t_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int unsigned m_cnt[CH], m_rld[CH], m_cap[CH];
    bit          m_ovf[CH], m_capf[CH], m_to[CH], m_done[CH];
    // pin sample history, index 0 = sample taken at the previous edge
    bit          m_th[CH][S+1], m_ih[CH][S+1], m_ch[CH][S+1];

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_cnt[c] = 0; m_rld[c] = 0; m_cap[c] = 0;
                m_ovf[c] = 0; m_capf[c] = 0; m_to[c] = 0; m_done[c] = 0;
                for (int j = 0; j <= S; j++) begin
                    m_th[c][j] = 1; m_ih[c][j] = 1; m_ch[c][j] = 1;
                end
            end else begin
                int unsigned md, old, nrld;
                bit int_s, tfall, cfall, en, tick, wcnt, ovf, capt;
                md    = 32'(mode[2*c +: 2]);
                int_s = m_ih[c][S-1];
                tfall = !m_th[c][S-1] && m_th[c][S];
                cfall = !m_ch[c][S-1] && m_ch[c][S];
                en    = tr[c] && !m_done[c] && (!gate[c] || int_s);
                tick  = en && (ct[c] ? tfall : 1'b1);
                wcnt  = wr_en[c] && !wr_sel;
                nrld  = (wr_en[c] && wr_sel) ? 32'(wr_data) : m_rld[c];
                old   = m_cnt[c];
                ovf   = tick && !wcnt && (old == MAXV);
                capt  = (md == 3) && cfall;
                if (wcnt) m_cnt[c] = 32'(wr_data);
                else if (tick) begin
                    m_cnt[c] = (old + 1) % (MAXV + 1);
                    if (ovf && (md == 1 || md == 2)) m_cnt[c] = nrld;
                end
                m_to[c]  = ovf;
                m_ovf[c] = ovf || (m_ovf[c] && !clr_ovf[c]);
                if (!tr[c]) m_done[c] = 0;
                else if (ovf && md == 2) m_done[c] = 1;
                if (capt) m_cap[c] = old;
                m_capf[c] = capt || (m_capf[c] && !clr_cap[c]);
                m_rld[c]  = nrld;
                for (int j = S; j > 0; j--) begin
                    m_th[c][j] = m_th[c][j-1];
                    m_ih[c][j] = m_ih[c][j-1];
                    m_ch[c][j] = m_ch[c][j-1];
                end
                m_th[c][0] = t_pin[c];
                m_ih[c][0] = int_pin[c];
                m_ch[c][0] = cap_pin[c];
            end
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        tr = '0; gate = '0; ct = '0; mode = '0;
        t_pin = '1; int_pin = '1; cap_pin = '1;
        wr_en = '0; wr_sel = 1'b0; wr_data = '0; clr_ovf = '0; clr_cap = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic wr(input int c, input logic sel, input logic [CNT_W-1:0] d);
        wr_en[c] = 1'b1; wr_sel = sel; wr_data = d;
        cyc();
        wr_en[c] = 1'b0; wr_sel = 1'b0;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int c);
        return cnt[c*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] cap_of(input int c);
        return cap[c*CNT_W +: CNT_W];
    endfunction

    typedef struct {
        logic [1:0]       md;
        logic [CNT_W-1:0] rld;
        logic [CNT_W-1:0] init;
        int               run;
        logic [CNT_W-1:0] e_cnt;
        logic             e_ovf;
        int               e_pulses;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int pulses;
        int k;
        logic [CH*CNT_W-1:0] e_cnt, e_cap;
        logic [CH-1:0]       e_ovf, e_capf, e_to;

        tbl[0] = '{2'd0, 16'h0000, 16'hFFFD,  3, 16'h0000, 1'b1, 1};
        tbl[1] = '{2'd1, 16'hFFF0, 16'hFFFF,  1, 16'hFFF0, 1'b1, 1};
        tbl[2] = '{2'd1, 16'hFFF0, 16'hFFFF, 17, 16'hFFF0, 1'b1, 2};
        tbl[3] = '{2'd2, 16'h0000, 16'hFFFE, 10, 16'h0000, 1'b1, 1};
        tbl[4] = '{2'd0, 16'h0000, 16'h1000,  5, 16'h1005, 1'b0, 0};
        tbl[5] = '{2'd3, 16'h0000, 16'h00FF,  4, 16'h0103, 1'b0, 0};
        tbl[6] = '{2'd2, 16'h1234, 16'hFFFF,  3, 16'h1234, 1'b1, 1};

        set_idle();
        rst = 1'b1;
        cyc();
        cyc();
        chk("reset_cnt", 64'(cnt), 64'd0);
        chk("reset_cap", 64'(cap), 64'd0);
        chk("reset_ovf", 64'(ovf_flag), 64'd0);
        chk("reset_capf", 64'(cap_flag), 64'd0);
        chk("reset_to", 64'(t_o), 64'd0);
        rst = 1'b0;

        // table vectors on channel 0; channel 1 stays stopped throughout
        for (int i = 0; i < 7; i++) begin
            set_idle();
            do_reset();
            mode[1:0] = tbl[i].md;
            tr[0] = 1'b1;
            wr(0, 1'b1, tbl[i].rld);
            wr(0, 1'b0, tbl[i].init);
            pulses = 0;
            repeat (tbl[i].run) begin
                cyc();
                if (t_o[0]) pulses++;
            end
            chk($sformatf("vec%0d_cnt", i), 64'(cnt_of(0)), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf_flag[0]), 64'(tbl[i].e_ovf));
            chk($sformatf("vec%0d_pulses", i), 64'(pulses), 64'(tbl[i].e_pulses));
            chk($sformatf("vec%0d_ch1_cnt", i), 64'(cnt_of(1)), 64'd0);
            chk($sformatf("vec%0d_ch1_flags", i), 64'({ovf_flag[1], cap_flag[1], t_o[1]}), 64'd0);
        end

        // free-run: t_o exactly on the third cycle after the write
        set_idle(); do_reset();
        tr[0] = 1'b1;
        wr(0, 1'b0, 16'hFFFD);
        cyc(); chk("fr_to_c1", 64'(t_o[0]), 64'd0);
        cyc(); chk("fr_to_c2", 64'(t_o[0]), 64'd0);
        cyc(); chk("fr_to_c3", 64'(t_o[0]), 64'd1);
        chk("fr_cnt", 64'(cnt_of(0)), 64'd0);
        cyc(); chk("fr_to_c4", 64'(t_o[0]), 64'd0);
        chk("fr_ovf", 64'(ovf_flag[0]), 64'd1);

        // reload: period of 16 cycles, sticky flag until cleared
        set_idle(); do_reset();
        mode[1:0] = 2'd1; tr[0] = 1'b1;
        wr(0, 1'b1, 16'hFFF0);
        wr(0, 1'b0, 16'hFFFF);
        cyc();
        chk("rl_first_to", 64'(t_o[0]), 64'd1);
        chk("rl_first_cnt", 64'(cnt_of(0)), 64'hFFF0);
        k = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (t_o[0]) begin k = n; break; end
        end
        chk("rl_period", 64'(k), 64'd16);
        chk("rl_ovf_sticky", 64'(ovf_flag[0]), 64'd1);
        clr_ovf[0] = 1'b1; cyc(); clr_ovf[0] = 1'b0;
        chk("rl_ovf_clr", 64'(ovf_flag[0]), 64'd0);

        // one-shot: stops after overflow, restarts after tr low
        set_idle(); do_reset();
        mode[1:0] = 2'd2; tr[0] = 1'b1;
        wr(0, 1'b1, 16'h0000);
        wr(0, 1'b0, 16'hFFFE);
        cyc(); cyc();
        chk("os_to", 64'(t_o[0]), 64'd1);
        cyc(); cyc(); cyc();
        chk("os_held", 64'(cnt_of(0)), 64'd0);
        tr[0] = 1'b0; cyc(); tr[0] = 1'b1;
        cyc(); cyc(); cyc();
        chk("os_resume", 64'(cnt_of(0)), 64'd3);

        // counter mode with gate: blocked while int_pin low, then sync latency per edge
        set_idle(); do_reset();
        ct[0] = 1'b1; gate[0] = 1'b1; int_pin[0] = 1'b0; tr[0] = 1'b1;
        wr(0, 1'b0, 16'h0100);
        repeat (4) cyc();
        repeat (5) begin
            t_pin[0] = 1'b0; cyc(); cyc(); cyc();
            t_pin[0] = 1'b1; cyc(); cyc();
        end
        chk("gate_blocked", 64'(cnt_of(0)), 64'h0100);
        int_pin[0] = 1'b1;
        repeat (4) cyc();
        for (int p = 1; p <= 5; p++) begin
            t_pin[0] = 1'b0; cyc(); cyc();
            chk($sformatf("cnt_early%0d", p), 64'(cnt_of(0)), 64'(16'h0100 + p - 1));
            cyc();
            chk($sformatf("cnt_edge%0d", p), 64'(cnt_of(0)), 64'(16'h0100 + p));
            t_pin[0] = 1'b1; cyc(); cyc();
        end

        // capture: pre-increment value, set beats clear
        set_idle(); do_reset();
        mode[1:0] = 2'd3; tr[0] = 1'b1;
        wr(0, 1'b0, 16'h1232);
        cap_pin[0] = 1'b0;
        cyc(); cyc();
        chk("cap_flag_early", 64'(cap_flag[0]), 64'd0);
        cyc();
        chk("cap_value", 64'(cap_of(0)), 64'h1234);
        chk("cap_flag_set", 64'(cap_flag[0]), 64'd1);
        chk("cap_cnt", 64'(cnt_of(0)), 64'h1235);
        cap_pin[0] = 1'b1; clr_cap[0] = 1'b1; cyc(); clr_cap[0] = 1'b0;
        chk("cap_flag_clr", 64'(cap_flag[0]), 64'd0);
        cyc(); cyc(); cyc();
        cap_pin[0] = 1'b0; cyc(); cyc();
        clr_cap[0] = 1'b1; cyc(); clr_cap[0] = 1'b0;
        chk("cap_set_beats_clr", 64'(cap_flag[0]), 64'd1);
        chk("cap_value2", 64'(cap_of(0)), 64'h123B);

        // reset just before an overflow edge: no spurious t_o
        set_idle(); do_reset();
        tr[0] = 1'b1;
        wr(0, 1'b0, 16'hFFFE);
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_mid_cnt", 64'(cnt), 64'd0);
        chk("rst_mid_to", 64'(t_o), 64'd0);
        chk("rst_mid_flags", 64'({ovf_flag, cap_flag}), 64'd0);
        chk("rst_mid_cap", 64'(cap), 64'd0);

        // randomized traffic against the model
        set_idle(); do_reset();
        tr = '1;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(299) == 0);
            for (int c = 0; c < CH; c++) begin
                tr[c]      = ($urandom_range(7) != 0);
                if ($urandom_range(19) == 0) gate[c] = $urandom_range(1) == 1;
                if ($urandom_range(19) == 0) ct[c]   = $urandom_range(1) == 1;
                if ($urandom_range(49) == 0) mode[2*c +: 2] = 2'($urandom_range(3));
                if ($urandom_range(2) == 0) t_pin[c]   = ~t_pin[c];
                if ($urandom_range(3) == 0) int_pin[c] = ~int_pin[c];
                if ($urandom_range(4) == 0) cap_pin[c] = ~cap_pin[c];
                wr_en[c]   = ($urandom_range(15) == 0);
                clr_ovf[c] = ($urandom_range(9) == 0);
                clr_cap[c] = ($urandom_range(9) == 0);
            end
            wr_sel  = $urandom_range(1) == 1;
            wr_data = ($urandom_range(1) == 1) ? CNT_W'($urandom)
                                               : CNT_W'(MAXV - $urandom_range(7));
            cyc();
            for (int c = 0; c < CH; c++) begin
                e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
                e_cap[c*CNT_W +: CNT_W] = CNT_W'(m_cap[c]);
                e_ovf[c]  = m_ovf[c];
                e_capf[c] = m_capf[c];
                e_to[c]   = m_to[c];
            end
            chk("rnd_cnt", 64'(cnt), 64'(e_cnt));
            chk("rnd_cap", 64'(cap), 64'(e_cap));
            chk("rnd_ovf", 64'(ovf_flag), 64'(e_ovf));
            chk("rnd_capf", 64'(cap_flag), 64'(e_capf));
            chk("rnd_to", 64'(t_o), 64'(e_to));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_array.md
Name: timer_array

Overview:
- Parametrised successor to the single 8051 timer: CH independent timer/counter channels of CNT_W bits each.
- Each channel supports the existing controls:
  - run (TR)
  - gate (GATE / INTx)
  - counter/timer select (C/T)
- New per channel:
  - full-width auto-reload
  - one-shot mode
  - capture mode with a sticky flag
  - input synchronisers and edge detection
- Sits in the peripheral block beside the SFR file, which drives the write, select and clear inputs.

Parameters:
- CH, 2, number of channels
- CNT_W, 16, counter/reload/capture width in bits (min 4)
- SYNC_STAGES, 2, synchroniser flops on each async pin (min 2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- tr  in  CH  per-channel run enable
- gate  in  CH  1 = counting also requires int_pin high
- ct  in  CH  0 = count clk cycles; 1 = count t_pin falling edges
- mode  in  2*CH  per-channel mode, channel i at [2i+1:2i]
- t_pin  in  CH  async external count input
- int_pin  in  CH  async gate input
- cap_pin  in  CH  async capture input
- wr_en  in  CH  write strobe
- wr_sel  in  1  0 = write counter, 1 = write reload register
- wr_data  in  CNT_W  write data, shared by all channels
- clr_ovf  in  CH  clear ovf_flag
- clr_cap  in  CH  clear cap_flag
- cnt  out  CH*CNT_W  current counts
- cap  out  CH*CNT_W  captured values
- ovf_flag  out  CH  sticky overflow flag (TFx)
- cap_flag  out  CH  sticky capture flag
- t_o  out  CH  one-cycle overflow pulse

Behaviour:
- Reset: cnt, reload, cap, ovf_flag, cap_flag, t_o, and the one-shot done latch all 0. Synchroniser flops reset to 1 (idle high), so no false edge after reset. Reset mid-count aborts immediately.
- Synchronisers: t_pin, int_pin and cap_pin each pass through SYNC_STAGES flops. A falling edge is detected on the last two stages and gives a one-cycle event.
  - Pin fall to count/capture takes effect at the cnt/cap register update SYNC_STAGES+1 clocks later.
- Enable: en = tr & ~done & (~gate | int_sync).
- Tick: tick = en & (ct ? t_fall : 1).
- Overflow: occurs when tick and cnt == all-ones. On overflow:
  - t_o pulses high for exactly one cycle, registered, same edge as the cnt update.
  - ovf_flag is set.
- Modes (localparam codes):
  - MODE_FREE=0: free-run, wraps to 0.
  - MODE_RELOAD=1: on overflow, cnt <= reload.
  - MODE_ONESHOT=2: on overflow, cnt <= reload and done <= 1; counting stops. done clears when tr is sampled low.
  - MODE_CAPTURE=3: free-run like mode 0. On cap_fall: cap <= cnt value before this cycle's increment, and cap_flag is set.
- Writes: wr_en[i] with wr_sel=0 loads cnt. A write beats a tick in the same cycle; no overflow or t_o results from that cycle.
  - With wr_sel=1, the write loads reload. An overflow in the same cycle uses the new value.
- Flags: set beats clear when both occur in the same cycle. Flags hold until cleared or reset.
- Mode changes take effect the next cycle; cnt is not modified by a mode change.
- Channels are fully independent. No combinational path from inputs to outputs.

Decomposition:
- Package timer_pkg holds:
  - mode localparams MODE_FREE, MODE_RELOAD, MODE_ONESHOT, MODE_CAPTURE
  - mode width constant MODE_W=2
- One natural sub-module, timer_channel: a single channel containing its synchronisers, edge detect, counter, reload, capture and flags.
- timer_array is a generate loop over CH instances of timer_channel plus port slicing.

Test Plan:
- Free-run, ct=0, tr=1, cnt written to 0xFFFD (CNT_W=16): t_o pulses exactly once, 3 cycles after the write. Then cnt=0x0000 and ovf_flag=1.
- Mode 1, reload=0xFFF0, cnt=0xFFFF, tr=1: overflow gives cnt=0xFFF0 and t_o pulses. Then t_o repeats every 16 cycles; ovf_flag stays 1 until clr_ovf.
- Mode 2, reload=0x0000, cnt=0xFFFE: one overflow, then cnt stays at 0x0000. Toggling tr low then high resumes counting.
- ct=1, gate=1, int_pin=0, 5 t_pin pulses: cnt unchanged. Then int_pin=1 and 5 t_pin pulses: cnt +5, each arriving SYNC_STAGES+1 clocks after its falling edge.
- Mode 3, cap_pin falls while counting at 0x1234: cap = pre-increment count with the sync latency; cap_flag=1. clr_cap and a second cap_fall in the same cycle: cap_flag stays 1.
- Channel 0 overflowing while channel 1 has tr=0: channel 1 cnt and flags unchanged. Asserting rst mid-count zeroes all outputs next cycle with no spurious t_o.
